// File: rtl/riscv_pkg.sv
// Shared widths and the write-back entry type used by the register-file
// write controller and its pending-write FIFO.
package riscv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes; exposes every slot
// with a valid bit so the owner can search it for bypass hits.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         valid
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [DEPTH-1:0]   r_valid;

  // Payload storage carries no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign rd_ptr  = r_rd_ptr;
  assign entries = r_mem;
  assign valid   = r_valid;
endmodule

// File: rtl/regfile_write_controller.sv
// Writer-side front end of the 32-entry register file: accepts write-backs,
// queues them in order, strobes one per cycle, and answers bypass lookups.
module regfile_write_controller
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         wb_hold,
  output logic [2**ADDR_WIDTH-1:0]     write_enable,
  output logic [DATA_WIDTH-1:0]        write_data,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr0,
  output logic                         lookup_hit0,
  output logic [DATA_WIDTH-1:0]        lookup_data0,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr1,
  output logic                         lookup_hit1,
  output logic [DATA_WIDTH-1:0]        lookup_data1,
  output logic [$clog2(DEPTH):0]       pending_count,
  output logic                         idle
);
  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t            w_push_entry;
  wb_entry_t            w_head;
  wb_entry_t            w_entries [DEPTH];
  logic [DEPTH-1:0]     w_valid;
  logic [PTR_W-1:0]     w_rd_ptr;
  logic [CNT_W-1:0]     w_count;
  logic                 w_push;
  logic                 w_pop;
  logic [NREGS-1:0]     r_write_enable;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [DATA_WIDTH:0]  w_byp0;
  logic [DATA_WIDTH:0]  w_byp1;

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    return NREGS'(1) << a;
  endfunction

  // Writes to x0 are accepted and dropped so they never reach the strobe.
  assign wb_ready     = (w_count < CNT_W'(DEPTH));
  assign w_push       = wb_valid && wb_ready && (wb_addr != '0);
  assign w_pop        = (w_count != '0) && !wb_hold;
  assign w_push_entry = '{addr: wb_addr, data: wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count),
    .rd_ptr     (w_rd_ptr),
    .entries    (w_entries),
    .valid      (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_enable <= '0;
      r_write_data   <= '0;
    end else if (w_pop) begin
      r_write_enable <= onehot(w_head.addr);
      r_write_data   <= w_head.data;
    end else begin
      r_write_enable <= '0;
    end
  end

  // Scan oldest to youngest so the youngest match wins; the staging
  // register is older than anything still in the FIFO.
  function automatic logic [DATA_WIDTH:0] bypass(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] res;
    logic [PTR_W-1:0]    idx;
    res = '0;
    if (a != '0) begin
      if (r_write_enable[a]) res = {1'b1, r_write_data};
      for (int i = 0; i < DEPTH; i++) begin
        idx = w_rd_ptr + PTR_W'(i);
        if (w_valid[idx] && (w_entries[idx].addr == a)) res = {1'b1, w_entries[idx].data};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_byp0 = bypass(lookup_addr0);
    w_byp1 = bypass(lookup_addr1);
  end

  assign lookup_hit0   = w_byp0[DATA_WIDTH];
  assign lookup_data0  = w_byp0[DATA_WIDTH-1:0];
  assign lookup_hit1   = w_byp1[DATA_WIDTH];
  assign lookup_data1  = w_byp1[DATA_WIDTH-1:0];
  assign write_enable  = r_write_enable;
  assign write_data    = r_write_data;
  assign pending_count = w_count;
  assign idle          = (w_count == '0) && (r_write_enable == '0);
endmodule

// File: tb/tb_regfile_write_controller.sv
// Directed bench for regfile_write_controller with a strobe scoreboard.
module tb_regfile_write_controller;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic [31:0] write_enable;
  logic [31:0] write_data;
  logic [4:0]  lookup_addr0;
  logic        lookup_hit0;
  logic [31:0] lookup_data0;
  logic [4:0]  lookup_addr1;
  logic        lookup_hit1;
  logic [31:0] lookup_data1;
  logic [2:0]  pending_count;
  logic        idle;

  int   total = 0;
  int   bad   = 0;
  int   nstrobe = 0;
  exp_t sb [$];

  regfile_write_controller dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_hold       (wb_hold),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .lookup_addr0  (lookup_addr0),
    .lookup_hit0   (lookup_hit0),
    .lookup_data0  (lookup_data0),
    .lookup_addr1  (lookup_addr1),
    .lookup_hit1   (lookup_hit1),
    .lookup_data1  (lookup_data1),
    .pending_count (pending_count),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; records what the bench expects the DUT to queue.
  task automatic tick();
    logic acc;
    acc = wb_valid && wb_ready && !reset;
    @(posedge clk);
    if (reset) sb.delete();
    else if (acc && wb_addr != 5'd0) sb.push_back('{addr: wb_addr, data: wb_data});
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && write_enable != 32'd0) begin
      exp_t e;
      nstrobe++;
      if (sb.size() == 0) begin
        chk("spurious_strobe", {32'd0, write_enable}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_we", {32'd0, write_enable}, {32'd0, 32'd1 << e.addr});
        chk("sb_data", {32'd0, write_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    int base;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_hold = 1'b0;
    lookup_addr0 = '0; lookup_addr1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", {63'd0, wb_ready}, 64'd1);
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_count", {61'd0, pending_count}, 64'd0);
    chk("rst_we", {32'd0, write_enable}, 64'd0);
    chk("rst_wdata", {32'd0, write_data}, 64'd0);

    // Single write: latency and one-cycle pulse
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    chk("t1_count", {61'd0, pending_count}, 64'd1);
    chk("t1_we_e1", {32'd0, write_enable}, 64'd0);
    tick();
    chk("t1_we_e2", {32'd0, write_enable}, 64'h20);
    chk("t1_wd_e2", {32'd0, write_data}, 64'hDEADBEEF);
    chk("t1_idle_e2", {63'd0, idle}, 64'd0);
    tick();
    chk("t1_we_e3", {32'd0, write_enable}, 64'd0);
    chk("t1_wd_hold", {32'd0, write_data}, 64'hDEADBEEF);
    chk("t1_idle_e3", {63'd0, idle}, 64'd1);

    // x0 write is swallowed
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    chk("x0_ready", {63'd0, wb_ready}, 64'd1);
    chk("x0_count", {61'd0, pending_count}, 64'd0);
    chk("x0_we_a", {32'd0, write_enable}, 64'd0);
    tick();
    chk("x0_we_b", {32'd0, write_enable}, 64'd0);

    // Fill under hold, then drain in order
    wb_hold = 1'b1; wb_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wb_addr = 5'(i); wb_data = 32'(i * 32'h100);
      tick();
    end
    chk("full_count", {61'd0, pending_count}, 64'd4);
    chk("full_ready", {63'd0, wb_ready}, 64'd0);
    wb_addr = 5'd5; wb_data = 32'h500;
    tick();
    chk("full_count2", {61'd0, pending_count}, 64'd4);
    chk("full_we", {32'd0, write_enable}, 64'd0);
    wb_hold = 1'b0;
    tick();
    chk("drain_we1", {32'd0, write_enable}, 64'h2);
    chk("drain_cnt1", {61'd0, pending_count}, 64'd3);
    chk("drain_ready", {63'd0, wb_ready}, 64'd1);
    tick();
    wb_valid = 1'b0;
    chk("drain_we2", {32'd0, write_enable}, 64'h4);
    chk("drain_cnt2", {61'd0, pending_count}, 64'd3);
    tick();
    chk("drain_we3", {32'd0, write_enable}, 64'h8);
    tick();
    chk("drain_we4", {32'd0, write_enable}, 64'h10);
    tick();
    chk("drain_we5", {32'd0, write_enable}, 64'h20);
    chk("drain_wd5", {32'd0, write_data}, 64'h500);
    tick();
    chk("drain_idle", {63'd0, idle}, 64'd1);

    // Bypass: youngest match wins, miss gives zero
    wb_hold = 1'b1; wb_valid = 1'b1;
    wb_addr = 5'd7; wb_data = 32'hA; tick();
    wb_data = 32'hB; tick();
    wb_valid = 1'b0;
    lookup_addr0 = 5'd7; lookup_addr1 = 5'd3; #1;
    chk("byp_hit0", {63'd0, lookup_hit0}, 64'd1);
    chk("byp_data0", {32'd0, lookup_data0}, 64'hB);
    chk("byp_hit1", {63'd0, lookup_hit1}, 64'd0);
    chk("byp_data1", {32'd0, lookup_data1}, 64'd0);
    lookup_addr1 = 5'd0; #1;
    chk("byp_x0_hit", {63'd0, lookup_hit1}, 64'd0);
    wb_hold = 1'b0;
    tick();
    chk("byp_mix_data", {32'd0, lookup_data0}, 64'hB);
    tick();
    chk("byp_stage_hit", {63'd0, lookup_hit0}, 64'd1);
    chk("byp_stage_data", {32'd0, lookup_data0}, 64'hB);
    tick();
    chk("byp_gone_hit", {63'd0, lookup_hit0}, 64'd0);
    chk("byp_gone_data", {32'd0, lookup_data0}, 64'd0);
    lookup_addr0 = 5'd0;

    // Reset discards queued writes
    wb_hold = 1'b1; wb_valid = 1'b1;
    for (int i = 9; i <= 11; i++) begin
      wb_addr = 5'(i); wb_data = 32'(i); tick();
    end
    wb_valid = 1'b0;
    chk("rq_count", {61'd0, pending_count}, 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0; wb_hold = 1'b0;
    chk("rq_count0", {61'd0, pending_count}, 64'd0);
    chk("rq_we0", {32'd0, write_enable}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rq_nostrobe", {32'd0, write_enable}, 64'd0);
    end

    // Back-to-back stream
    base = nstrobe;
    wb_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wb_addr = 5'((i % 31) + 1); wb_data = $urandom;
      last_addr = wb_addr; last_data = wb_data;
      chk("b2b_ready", {63'd0, wb_ready}, 64'd1);
      tick();
    end
    wb_valid = 1'b0;
    tick();
    chk("b2b_last_we", {32'd0, write_enable}, {32'd0, 32'd1 << last_addr});
    chk("b2b_last_wd", {32'd0, write_data}, {32'd0, last_data});
    tick();
    chk("b2b_end_we", {32'd0, write_enable}, 64'd0);
    chk("b2b_nstrobe", 64'(nstrobe - base), 64'd20);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
